dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Parametrised byte-addressed data memory with integrated load/store unit. Accepts
//  one request per cycle over a valid/ready handshake: byte/half/word loads and stores,
//  sign or zero extension, and misaligned word-crossing accesses split into two beats.
//  Returns a one-cycle response pulse with data and error. Sits between CPU MEM stage and RAM.
// PARAMETERS
//  DEPTH_BYTES      512  memory size in bytes; power of 2, multiple of 4
//  ADDR_W           32   request address width
//  ALLOW_MISALIGNED 1    1: word-crossing accesses split into 2 beats; 0: flagged as error
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       request can be accepted this cycle
//  req_we       in   1       1 store, 0 load
//  req_size     in   2       mem_size_e: 00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1       load: 1 zero-extend, 0 sign-extend (ignored for stores/word)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid   out  1       one-cycle completion pulse (loads and stores)
//  resp_rdata   out  32      extended load data; 0 for stores and errors
//  resp_err     out  1       access faulted; valid with resp_valid
// BEHAVIOUR
//  - Reset: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0; memory contents NOT reset.
//  - Accept = req_valid && req_ready. req_ready=1 in IDLE, 0 in SPLIT and during rst.
//  - Error if any of: req_size==11; addr+nbytes-1 >= DEPTH_BYTES; word-crossing with
//    ALLOW_MISALIGNED=0. Errored access: no write, resp 1 cycle after accept, err=1, rdata=0.
//  - Word-crossing: (addr[1:0] + nbytes) > 4. Half at offset 3, word at offsets 1..3.
//  - Aligned/non-crossing (N = accept cycle): store bytes written at posedge ending N;
//    load row read at that edge; resp_valid in N+1. State stays IDLE -> back-to-back 1/cycle.
//  - Crossing: IDLE->SPLIT on accept. Beat 1 (edge ending N) accesses row addr>>2, lanes
//    addr[1:0]..3; beat 2 (edge ending N+1, SPLIT) accesses row+1, remaining low lanes.
//    SPLIT->IDLE unconditionally; resp_valid in N+2. req_ready=0 in N+1.
//  - Lanes: store byte k of req_wdata goes to memory byte addr+k (little-endian).
//    Load assembles bytes addr..addr+nbytes-1 little-endian, then extends from bit 7/15.
//  - Store followed by load to same bytes next cycle returns new data (write precedes read).
//  - Only addr bits [clog2(DEPTH_BYTES)-1:0] index; higher set bits fall in the range check.
//  - Reset in SPLIT: beat 2 abandoned, beat-1 bytes of a store remain written, no resp.
//  - Reset wins over a same-cycle request; request is dropped.
// STRUCTURE
//  - dmem_pkg: typedef enum logic[1:0] mem_size_e {SZ_B,SZ_H,SZ_W};
//    typedef enum logic state_e {IDLE,SPLIT}; function nbytes(mem_size_e).
//  - Sub-module dmem_bank: DEPTH_BYTES/4 x 32 array, 4-bit byte-lane write enable,
//    one row address per cycle, synchronous read, shared read/write address.
//  - dmem_lsu holds FSM, range/alignment check, lane steering, beat-1 data capture,
//    extension, and response registers.
// TESTING
//  1. Reset, then sw 0xDEADBEEF @0x10; lw @0x10 -> resp N+1 each, rdata 0xDEADBEEF, err=0.
//  2. sb 0x80 @0x21; lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080; lhu @0x20 -> 0x00008000
//     given prior sw 0 @0x20.
//  3. ALLOW_MISALIGNED=1: sw 0x11223344 @0x0E -> req_ready=0 one cycle, resp N+2;
//     lw @0x0C -> 0x33440000 lower half from prior zeros; lw @0x10 low half 0x1122.
//  4. Errors: lw @0x1FE (DEPTH 512) -> err=1, rdata=0, @0x1FE unchanged; size=11 -> err;
//     ALLOW_MISALIGNED=0 lh @0x03 -> err=1, latency 1.
//  5. Back-to-back: 8 aligned sw then 8 lw on consecutive cycles -> req_ready stays 1,
//     8 resp pulses each, data matches.
//  6. Assert rst in SPLIT of misaligned store @0x0E -> no resp, bytes 0x0E-0x0F written,
//     0x10-0x11 unchanged, req_ready=1 after rst drops.

Source files
------------

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// dmem_pkg : shared types and helpers for the data-memory load/store unit
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Illegal encoding reports one byte so the range math stays well-formed.
  function automatic logic [2:0] nbytes(mem_size_e sz);
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      SZ_W:    nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_if.sv
//------------------------------------------------------------------------------
// dmem_lsu_if : request/response bus between the CPU MEM stage and dmem_lsu
// Rev 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_lsu_bank.sv
//------------------------------------------------------------------------------
// dmem_bank : word-wide RAM, per-byte write enables, shared address, sync read
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_bank #(
  parameter int ROWS = 128,
  parameter int RW   = 7
) (
  input  wire logic          clk,
  input  wire logic [RW-1:0] i_row,
  input  wire logic [3:0]    i_be,
  input  wire logic [31:0]   i_wdata,
  output logic      [31:0]   o_rdata
);
  logic [31:0] r_mem [ROWS];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) r_mem[i_row][8*k +: 8] <= i_wdata[8*k +: 8];
    end
    o_rdata <= r_mem[i_row];
  end
endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
//------------------------------------------------------------------------------
// dmem_lsu : byte-addressed data memory with load/store unit, splits
//            word-crossing accesses into two beats
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES      = 512,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input wire logic  clk,
  input wire logic  rst,
  dmem_lsu_if.slave bus
);
  localparam int AW   = $clog2(DEPTH_BYTES);
  localparam int RW   = AW - 2;
  localparam int ROWS = DEPTH_BYTES / 4;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH_BYTES);

  state_e          r_state;
  logic            r_rsp_valid, r_rsp_err;
  logic [RW-1:0]   r_row;
  logic [1:0]      r_off;
  mem_size_e       r_size;
  logic            r_uns, r_we, r_cross;
  logic [3:0]      r_be_hi;
  logic [31:0]     r_wd_hi, r_lo;

  mem_size_e       w_size;
  logic [2:0]      w_nb;
  logic [1:0]      w_off;
  logic [3:0]      w_mask;
  logic [ADDR_W:0] w_last;
  logic            w_cross, w_err, w_ready, w_accept, w_split_go;
  logic [7:0]      w_be_wide;
  logic [63:0]     w_wd_wide, w_rd_wide;
  logic [RW-1:0]   w_row;
  logic [3:0]      w_be;
  logic [31:0]     w_wd, w_bank_rd, w_sh, w_ext;

  assign w_size     = mem_size_e'(bus.req_size);
  assign w_nb       = nbytes(w_size);
  assign w_off      = bus.req_addr[1:0];
  assign w_mask     = (w_nb == 3'd1) ? 4'b0001 : (w_nb == 3'd2) ? 4'b0011 : 4'b1111;
  assign w_last     = {1'b0, bus.req_addr} + (ADDR_W+1)'(w_nb) - (ADDR_W+1)'(1);
  assign w_cross    = ({1'b0, w_off} + w_nb) > 3'd4;
  assign w_err      = (bus.req_size == 2'b11) || (w_last >= c_depth) ||
                      (w_cross && (ALLOW_MISALIGNED == 0));
  assign w_ready    = (r_state == IDLE) && !rst;
  assign w_accept   = bus.req_valid && w_ready;
  assign w_split_go = w_accept && !w_err && w_cross;
  assign w_be_wide  = {4'b0000, w_mask} << w_off;
  assign w_wd_wide  = {32'd0, bus.req_wdata} << {w_off, 3'b000};

  // Beat 2 of a split access owns the bank; reset abandons its write.
  always_comb begin
    w_row = bus.req_addr[AW-1:2];
    w_be  = 4'b0000;
    w_wd  = w_wd_wide[31:0];
    if (r_state == SPLIT) begin
      w_row = r_row + RW'(1);
      w_wd  = r_wd_hi;
      if (r_we && !rst) w_be = r_be_hi;
    end else if (w_accept && bus.req_we && !w_err) begin
      w_be = w_be_wide[3:0];
    end
  end

  dmem_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
    .clk     (clk),
    .i_row   (w_row),
    .i_be    (w_be),
    .i_wdata (w_wd),
    .o_rdata (w_bank_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_cross     <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_rsp_valid <= (w_accept && !w_split_go) || (r_state == SPLIT);
      r_rsp_err   <= w_accept && w_err;
      if (w_accept) begin
        r_row   <= bus.req_addr[AW-1:2];
        r_off   <= w_off;
        r_size  <= w_size;
        r_uns   <= bus.req_unsigned;
        r_we    <= bus.req_we;
        r_cross <= w_split_go;
        r_be_hi <= w_be_wide[7:4];
        r_wd_hi <= w_wd_wide[63:32];
      end
      r_state <= (r_state == IDLE && w_split_go) ? SPLIT : IDLE;
    end
    if (r_state == SPLIT) r_lo <= w_bank_rd;
  end

  assign w_rd_wide = r_cross ? {w_bank_rd, r_lo} : {32'd0, w_bank_rd};
  assign w_sh      = 32'(w_rd_wide >> {r_off, 3'b000});

  always_comb begin
    case (r_size)
      SZ_B:    w_ext = r_uns ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}},  w_sh[7:0]};
      SZ_H:    w_ext = r_uns ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_rsp_valid;
  assign bus.resp_err   = r_rsp_valid && r_rsp_err;
  assign bus.resp_rdata = (r_rsp_valid && !r_rsp_err && !r_we) ? w_ext : 32'd0;
endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
//------------------------------------------------------------------------------
// tb_dmem_lsu : directed self-checking bench for dmem_lsu (misaligned on/off)
// Rev 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_W(32)) bus0 ();
  dmem_lsu_if #(.ADDR_W(32)) bus1 ();

  dmem_lsu #(.DEPTH_BYTES(512), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dmem_lsu #(.DEPTH_BYTES(512), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    if (sel) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_size = sz;
      bus1.req_unsigned = uns; bus1.req_addr = addr; bus1.req_wdata = wd;
    end else begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_size = sz;
      bus0.req_unsigned = uns; bus0.req_addr = addr; bus0.req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus1.req_ready : bus0.req_ready;
  endfunction
  function automatic logic rv(input bit sel);
    return sel ? bus1.resp_valid : bus0.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input bit sel);
    return sel ? bus1.resp_rdata : bus0.resp_rdata;
  endfunction
  function automatic logic rerr(input bit sel);
    return sel ? bus1.resp_err : bus0.resp_err;
  endfunction

  // One isolated transaction; latency is measured in cycles after the accept edge.
  task automatic access(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rd, input bit exp_err, input string tag);
    int   lat;
    logic rdy1;
    drive(sel, 1'b1, we, sz, uns, addr, wd);
    check({tag, "/ready"}, 32'(rdy(sel)), 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    rdy1 = rdy(sel);
    lat  = 1;
    while (!rv(sel) && lat < 5) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/ready_after"}, 32'(rdy1), (exp_lat == 2) ? 32'd0 : 32'd1);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, rdat(sel), exp_rd);
    check({tag, "/err"}, 32'(rerr(sel)), 32'(exp_err));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", 32'(bus0.req_ready), 32'd0);
    check("rst/resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst/rdata", bus0.resp_rdata, 32'd0);
    check("rst/err", 32'(bus0.resp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst/ready", 32'(bus0.req_ready), 32'd1);

    // word store/load
    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, "sw10");
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, "lw10");

    // byte/half extension
    access(0, 1, 2'b10, 0, 32'h20, 32'h0, 1, 32'h0, 0, "sw20");
    access(0, 1, 2'b00, 0, 32'h21, 32'h80, 1, 32'h0, 0, "sb21");
    access(0, 0, 2'b00, 0, 32'h21, 32'h0, 1, 32'hFFFFFF80, 0, "lb21");
    access(0, 0, 2'b00, 1, 32'h21, 32'h0, 1, 32'h00000080, 0, "lbu21");
    access(0, 0, 2'b01, 1, 32'h20, 32'h0, 1, 32'h00008000, 0, "lhu20");
    access(0, 0, 2'b01, 0, 32'h20, 32'h0, 1, 32'hFFFF8000, 0, "lh20");

    // word-crossing split accesses
    access(0, 1, 2'b10, 0, 32'h0C, 32'h0, 1, 32'h0, 0, "sw0C_clr");
    access(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h0, 0, "sw10_clr");
    access(0, 1, 2'b10, 0, 32'h0E, 32'h11223344, 2, 32'h0, 0, "sw0E_mis");
    access(0, 0, 2'b10, 0, 32'h0C, 32'h0, 1, 32'h33440000, 0, "lw0C");
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h00001122, 0, "lw10b");
    access(0, 0, 2'b10, 0, 32'h0E, 32'h0, 2, 32'h11223344, 0, "lw0E_mis");
    access(0, 0, 2'b01, 0, 32'h0F, 32'h0, 2, 32'h00002233, 0, "lh0F_mis");

    // errors
    access(0, 1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 1, 32'h0, 0, "sw1FC");
    access(0, 1, 2'b10, 0, 32'h1FE, 32'hFFFFFFFF, 1, 32'h0, 1, "sw1FE_err");
    access(0, 0, 2'b10, 0, 32'h1FE, 32'h0, 1, 32'h0, 1, "lw1FE_err");
    access(0, 0, 2'b10, 0, 32'h1FC, 32'h0, 1, 32'hCAFEF00D, 0, "lw1FC_keep");
    access(0, 0, 2'b11, 0, 32'h30, 32'h0, 1, 32'h0, 1, "size11_err");
    access(0, 0, 2'b10, 0, 32'h10000010, 32'h0, 1, 32'h0, 1, "hiaddr_err");
    access(1, 1, 2'b10, 0, 32'h04, 32'hA5A5_5A5A, 1, 32'h0, 0, "nm_sw04");
    access(1, 0, 2'b10, 0, 32'h04, 32'h0, 1, 32'hA5A55A5A, 0, "nm_lw04");
    access(1, 0, 2'b01, 0, 32'h03, 32'h0, 1, 32'h0, 1, "nm_lh03_err");

    // back-to-back aligned traffic, one request per cycle
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h80 + 32'(4*i), 32'h10000000 + 32'(i*32'h0101));
        check("b2b_sw/ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk); #1;
        if (bus0.resp_valid) pulses++;
      end
      check("b2b_sw/pulses", 32'(pulses), 32'd8);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80 + 32'(4*i), 32'h0);
        check("b2b_lw/ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk); #1;
        if (bus0.resp_valid) pulses++;
        check("b2b_lw/rdata", bus0.resp_rdata, 32'h10000000 + 32'(i*32'h0101));
      end
      check("b2b_lw/pulses", 32'(pulses), 32'd8);
      drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'hC0, 32'h5A5A1234);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hC0, 32'h0);
      @(posedge clk); #1;
      check("st_ld_fwd/rdata", bus0.resp_rdata, 32'h5A5A1234);
      drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      check("b2b_idle/resp_valid", 32'(bus0.resp_valid), 32'd0);
    end

    // reset during the second beat of a split store
    access(0, 1, 2'b10, 0, 32'h0C, 32'h0, 1, 32'h0, 0, "rs_clr0C");
    access(0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 32'h0, 0, "rs_clr10");
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0E, 32'hAABBCCDD);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("rs_split/ready", 32'(bus0.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rs_split/resp_valid", 32'(bus0.resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rs_after/ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk); #1;
    check("rs_after/resp_valid", 32'(bus0.resp_valid), 32'd0);
    access(0, 0, 2'b10, 0, 32'h0C, 32'h0, 1, 32'hCCDD0000, 0, "rs_lw0C");
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h00000000, 0, "rs_lw10");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
